// File: rtl/bcd_seg_display_pkg.sv
// Shared types and active-low 7-segment patterns for the sequential BCD display driver.
package bcd_seg_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_seg_display_if.sv
// Load/ready/done handshake and display result bundle of the BCD display driver.
interface bcd_seg_display_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  load;
  logic [BIN_W-1:0]      bin;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   seg;

  modport master (
    output load, bin,
    input  ready, busy, done, overflow, bcd, seg
  );

  modport slave (
    input  load, bin,
    output ready, busy, done, overflow, bcd, seg
  );
endinterface

// File: rtl/bcd_seg_display_seg7_encode.sv
// One display digit: BCD nibble to active-low segments, with dash and blank overrides.
module seg7_encode
  import bcd_seg_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  // Dash has priority so an overflowed result never shows blanked digits
  always_comb begin
    seg = seg_digit(digit);
    if (dash)
      seg = SEG_DASH;
    else if (blank)
      seg = SEG_BLANK;
  end

endmodule

// File: rtl/bcd_seg_display.sv
// Sequential double-dabble binary->BCD converter with registered 7-segment outputs.
// state  | meaning
// IDLE   | waiting for load, outputs hold last result
// SHIFT  | one add-3/shift step per cycle, BIN_W cycles
// DONE   | one-cycle done pulse, new load may be accepted
module bcd_seg_display
  import bcd_seg_display_pkg::*;
#(
  parameter int BIN_W    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  bcd_seg_display_if.slave       bus
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam int SW = 4 * DIGITS;

  state_t              state, state_n;
  logic [CW-1:0]       cnt;
  logic [BIN_W-1:0]    shreg;
  logic [SW-1:0]       scratch, adj, scratch_n;
  logic                ovf, ovf_n;
  logic                accept, last;
  logic [DIGITS-1:0]   blank;
  logic [7*DIGITS-1:0] seg_n;
  logic [SW-1:0]       bcd_q;
  logic [7*DIGITS-1:0] seg_q;
  logic                ovf_q;

  function automatic logic [7*DIGITS-1:0] seg_reset();
    logic [7*DIGITS-1:0] r;
    for (int k = 0; k < DIGITS; k++)
      r[7*k +: 7] = (k > 0 && BLANK_LZ != 0) ? SEG_BLANK : SEG_0;
    return r;
  endfunction

  assign accept = bus.load && (state == ST_IDLE || state == ST_DONE);
  assign last   = (state == ST_SHIFT) && (cnt == CW'(1));

  // Per-digit add-3 correction; carries never cross digit boundaries
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    assign adj[4*k +: 4] = (scratch[4*k +: 4] >= 4'd5) ? scratch[4*k +: 4] + 4'd3
                                                        : scratch[4*k +: 4];
  end

  assign scratch_n = {adj[SW-2:0], shreg[BIN_W-1]};
  assign ovf_n     = ovf | adj[SW-1];

  // Encoders look at the value about to be latched so seg updates with bcd
  for (genvar k = 0; k < DIGITS; k++) begin : g_enc
    if (k == 0) begin : g_units
      assign blank[k] = 1'b0;
    end else begin : g_upper
      assign blank[k] = (BLANK_LZ != 0) && (scratch_n[SW-1:4*k] == '0);
    end
    seg7_encode u_enc (
      .digit (scratch_n[4*k +: 4]),
      .blank (blank[k]),
      .dash  (ovf_n),
      .seg   (seg_n[7*k +: 7])
    );
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (bus.load) state_n = ST_SHIFT;
      ST_SHIFT: if (last) state_n = ST_DONE;
      ST_DONE:  state_n = bus.load ? ST_SHIFT : ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      scratch <= '0;
      ovf     <= 1'b0;
      bcd_q   <= '0;
      seg_q   <= seg_reset();
      ovf_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        shreg   <= bus.bin;
        scratch <= '0;
        ovf     <= 1'b0;
        cnt     <= CW'(BIN_W);
      end else if (state == ST_SHIFT) begin
        shreg   <= {shreg[BIN_W-2:0], 1'b0};
        scratch <= scratch_n;
        ovf     <= ovf_n;
        cnt     <= cnt - CW'(1);
        if (last) begin
          bcd_q <= scratch_n;
          seg_q <= seg_n;
          ovf_q <= ovf_n;
        end
      end
    end
  end

  assign bus.ready    = (state == ST_IDLE) || (state == ST_DONE);
  assign bus.busy     = (state == ST_SHIFT);
  assign bus.done     = (state == ST_DONE);
  assign bus.overflow = ovf_q;
  assign bus.bcd      = bcd_q;
  assign bus.seg      = seg_q;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Directed bench: default, no-blanking and two-digit instances driven side by side.
module tb_bcd_seg_display;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bcd_seg_display_if #(.BIN_W(8), .DIGITS(3)) if_a  ();
  bcd_seg_display_if #(.BIN_W(8), .DIGITS(3)) if_nb ();
  bcd_seg_display_if #(.BIN_W(8), .DIGITS(2)) if_d2 ();

  bcd_seg_display #(.BIN_W(8), .DIGITS(3), .BLANK_LZ(1)) u_a  (.clk(clk), .reset(reset), .bus(if_a));
  bcd_seg_display #(.BIN_W(8), .DIGITS(3), .BLANK_LZ(0)) u_nb (.clk(clk), .reset(reset), .bus(if_nb));
  bcd_seg_display #(.BIN_W(8), .DIGITS(2), .BLANK_LZ(1)) u_d2 (.clk(clk), .reset(reset), .bus(if_d2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse load on all three instances; returns done cycle and busy cycles seen before it
  task automatic convert(input logic [7:0] va, input logic [7:0] vn, input logic [7:0] v2,
                         output int lat, output int nbusy);
    if_a.load = 1'b1;  if_a.bin = va;
    if_nb.load = 1'b1; if_nb.bin = vn;
    if_d2.load = 1'b1; if_d2.bin = v2;
    step();
    if_a.load = 1'b0; if_nb.load = 1'b0; if_d2.load = 1'b0;
    lat = -1;
    nbusy = 0;
    for (int c = 1; c <= 15; c++) begin
      if (if_a.done) begin
        lat = c;
        break;
      end
      if (if_a.busy) nbusy++;
      step();
    end
    check("latency", lat, 9);
  endtask

  initial begin
    int lat, nbusy, npulse, first, second;
    if_a.load = 1'b0;  if_a.bin = '0;
    if_nb.load = 1'b0; if_nb.bin = '0;
    if_d2.load = 1'b0; if_d2.bin = '0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;

    // Reset state
    check("rst_ready", if_a.ready, 1'b1);
    check("rst_busy", if_a.busy, 1'b0);
    check("rst_done", if_a.done, 1'b0);
    check("rst_bcd", if_a.bcd, 12'h000);
    check("rst_ovf", if_a.overflow, 1'b0);
    check("rst_seg", if_a.seg, {7'h7F, 7'h7F, 7'h40});
    check("rst_seg_nb", if_nb.seg, {7'h40, 7'h40, 7'h40});
    check("rst_seg_d2", if_d2.seg, {7'h7F, 7'h40});

    // 255 through the full range, zero on the other instances
    convert(8'd255, 8'd0, 8'd0, lat, nbusy);
    check("b255_busy_cycles", nbusy, 8);
    check("b255_done", if_a.done, 1'b1);
    check("b255_busy_in_done", if_a.busy, 1'b0);
    check("b255_bcd", if_a.bcd, 12'h255);
    check("b255_ovf", if_a.overflow, 1'b0);
    check("b255_seg", if_a.seg, {7'b0100100, 7'b0010010, 7'b0010010});
    check("b0_nb_seg", if_nb.seg, {7'h40, 7'h40, 7'h40});
    check("b0_d2_seg", if_d2.seg, {7'h7F, 7'h40});
    step();
    check("b255_done_once", if_a.done, 1'b0);
    check("b255_ready_after", if_a.ready, 1'b1);
    check("b255_bcd_hold", if_a.bcd, 12'h255);

    // Small value: blanking versus all-zeros display
    convert(8'd7, 8'd7, 8'd37, lat, nbusy);
    check("b7_bcd", if_a.bcd, 12'h007);
    check("b7_seg", if_a.seg, {7'h7F, 7'h7F, 7'h78});
    check("b7_nb_seg", if_nb.seg, {7'h40, 7'h40, 7'h78});
    check("b37_d2_bcd", if_d2.bcd, 8'h37);
    check("b37_d2_seg", if_d2.seg, {7'b0110000, 7'b1111000});
    step();

    // Load held high, bin changed while busy, back-to-back acceptance in DONE
    if_a.load = 1'b1;
    if_a.bin = 8'd100;
    step();
    if_a.bin = 8'd42;
    npulse = 0; first = -1; second = -1;
    for (int c = 1; c <= 22; c++) begin
      if (if_a.done) begin
        npulse++;
        if (first < 0) first = c; else second = c;
      end
      if (c == 9) begin
        check("b2b_first_bcd", if_a.bcd, 12'h100);
        check("b2b_first_seg", if_a.seg, {7'b1111001, 7'h40, 7'h40});
      end
      if (c == 10) begin
        check("b2b_reaccept_busy", if_a.busy, 1'b1);
        if_a.load = 1'b0;
      end
      step();
    end
    check("b2b_pulses", npulse, 2);
    check("b2b_first_cycle", first, 9);
    check("b2b_second_cycle", second, 18);
    check("b2b_second_bcd", if_a.bcd, 12'h042);
    check("b2b_second_seg", if_a.seg, {7'h7F, 7'b0011001, 7'b0100100});

    // Two-digit overflow, then a fitting value clears it
    convert(8'd0, 8'd0, 8'd200, lat, nbusy);
    check("ovf_flag", if_d2.overflow, 1'b1);
    check("ovf_bcd", if_d2.bcd, 8'h00);
    check("ovf_seg", if_d2.seg, {7'b0111111, 7'b0111111});
    step();
    convert(8'd0, 8'd0, 8'd99, lat, nbusy);
    check("ovf_clear_flag", if_d2.overflow, 1'b0);
    check("ovf_clear_bcd", if_d2.bcd, 8'h99);
    check("ovf_clear_seg", if_d2.seg, {7'b0010000, 7'b0010000});
    step();

    // Reset mid-conversion discards work
    if_a.load = 1'b1;
    if_a.bin = 8'd123;
    step();
    if_a.load = 1'b0;
    step();
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst_ready", if_a.ready, 1'b1);
    check("midrst_busy", if_a.busy, 1'b0);
    check("midrst_done", if_a.done, 1'b0);
    check("midrst_bcd", if_a.bcd, 12'h000);
    check("midrst_ovf_d2", if_d2.overflow, 1'b0);
    npulse = 0;
    for (int c = 0; c < 12; c++) begin
      if (if_a.done) npulse++;
      step();
    end
    check("midrst_no_done", npulse, 0);
    convert(8'd123, 8'd0, 8'd0, lat, nbusy);
    check("reload_bcd", if_a.bcd, 12'h123);
    check("reload_seg", if_a.seg, {7'b1111001, 7'b0100100, 7'b0110000});
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
